ahb_bus_arbiter: RTL and testbench

- Central AHB arbiter that shares the single AHB master port among NUM_M bus masters, e.g. instruction-fetch and data-access AHB interfaces.
- Samples each master's HBUSREQ and drives a one-hot HGRANT back to the masters.
- Drives HMASTER (address-phase owner) and a delayed data-phase owner, used by the bus address/control mux and the write-data mux.
- Re-arbitrates only on transfer boundaries. A tenure limit bounds how long one master can hold the bus.

---
 rtl/ahb_bus_arbiter_pkg.sv | 31 +++
 rtl/ahb_arb_pick.sv | 71 +++++++
 rtl/ahb_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ahb_bus_arbiter_pkg
//   Shared definitions for the central AHB arbiter and its picker:
//     - HTRANS encodings seen on the muxed master bus
//     - arbiter FSM state encodings (ARB_PARK / ARB_OWN)
//     - default master count and tenure-counter width
//   Imported by ahb_arb_pick and ahb_bus_arbiter.
// ---------------------------------------------------------------------------
package ahb_bus_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int DEF_NUM_M = 2;

  // Tenure counter is wide enough for the largest legal MAX_TENURE (255).
  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    ARB_PARK = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  // NONSEQ and SEQ both carry HTRANS[1]=1; only those count as transfers.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// ---------------------------------------------------------------------------
// ahb_arb_pick
//   Purely combinational winner picker for the AHB arbiter.
//   Build option AHB_ARB_RR_EN:
//     defined   - round-robin: search starts at (owner+1) mod NUM_M and wraps,
//                 the owner itself is the last candidate.
//     undefined - fixed priority: lowest index wins.
//   In both modes 'excl' removes the current owner from the candidate set.
//
// Ports:
//   req    in  NUM_M  request vector (bit i = master i)
//   owner  in  MW     current address-phase owner
//   excl   in  1      exclude the owner from the search
//   win    out MW     winning master index (0 when vld=0)
//   vld    out 1      at least one eligible requester
// ---------------------------------------------------------------------------
module ahb_arb_pick
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int NUM_M = DEF_NUM_M,
  parameter int MW    = 3
) (
  input  logic [NUM_M-1:0] req,
  input  logic [MW-1:0]    owner,
  input  logic             excl,
  output logic [MW-1:0]    win,
  output logic             vld
);

  logic [NUM_M-1:0] masked;

  always_comb begin
    masked = '0;
    for (int i = 0; i < NUM_M; i++) begin
      masked[i] = req[i] & ~(excl && (owner == MW'(i)));
    end
  end

`ifdef AHB_ARB_RR_EN
  // Rotating priority: candidate distance from (owner+1) modulo NUM_M; the
  // smallest distance wins, so the owner (distance NUM_M-1) is always last.
  always_comb begin
    int dist;
    int best;
    win  = '0;
    vld  = 1'b0;
    dist = 0;
    best = NUM_M;
    for (int i = 0; i < NUM_M; i++) begin
      dist = (i + NUM_M - int'(owner) - 1) % NUM_M;
      if (masked[i] && (dist < best)) begin
        best = dist;
        vld  = 1'b1;
        win  = MW'(i);
      end
    end
  end
`else
  always_comb begin
    win = '0;
    vld = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (masked[i] && !vld) begin
        vld = 1'b1;
        win = MW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bus_arbiter
//   Central AHB arbiter sharing one AHB master port among NUM_M masters.
//   Re-arbitrates only on completed transfers (hready_i=1), never splits a
//   SEQ burst, and bounds bus tenure to MAX_TENURE transfers when another
//   master is waiting. Picker flavour is selected by AHB_ARB_RR_EN
//   (round-robin when defined, fixed lowest-index priority otherwise).
//
// Ports:
//   clk          in  1      system clock, rising edge
//   rst          in  1      asynchronous active-low reset
//   hbusreq_i    in  NUM_M  per-master bus request
//   htrans_i     in  2      HTRANS of the currently granted master
//   hready_i     in  1      bus HREADY, transfer completes this cycle
//   hgrant_o     out NUM_M  registered one-hot grant
//   hmaster_o    out MW     registered address-phase owner
//   hmaster_d_o  out MW     registered data-phase owner
//   parked_o     out 1      grant parked on DEF_MASTER with no request
// ---------------------------------------------------------------------------
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int NUM_M      = DEF_NUM_M,
  parameter int MW         = 3,
  parameter int DEF_MASTER = 0,
  parameter int MAX_TENURE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] hbusreq_i,
  input  logic [1:0]       htrans_i,
  input  logic             hready_i,
  output logic [NUM_M-1:0] hgrant_o,
  output logic [MW-1:0]    hmaster_o,
  output logic [MW-1:0]    hmaster_d_o,
  output logic             parked_o
);

  localparam logic [MW-1:0]    DEF_IDX   = MW'(DEF_MASTER);
  localparam logic [NUM_M-1:0] DEF_GRANT = NUM_M'(1) << DEF_MASTER;
  localparam logic [CNT_W-1:0] TEN_MAX   = CNT_W'(MAX_TENURE);

  arb_state_e       state_p0;
  arb_state_e       state_nx;
  logic [MW-1:0]    owner_p0;
  logic [MW-1:0]    owner_nx;
  logic [MW-1:0]    owner_p1;
  logic [NUM_M-1:0] grant_p0;
  logic [NUM_M-1:0] grant_nx;
  logic [CNT_W-1:0] tenure_p0;
  logic [CNT_W-1:0] tenure_nx;

  logic             owner_req;
  logic             pick_excl;
  logic [MW-1:0]    pick_win;
  logic             pick_vld;

  function automatic logic [CNT_W-1:0] tenure_sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= TEN_MAX) begin
      return TEN_MAX;
    end
    return cnt + CNT_W'(1);
  endfunction

  // While owning, the picker only ever needs to look at the other masters:
  // in rule (b) the owner's request is already low, in rule (c) it must
  // yield. In PARK the default master is a legal winner.
  assign pick_excl = (state_p0 == ARB_OWN);

  ahb_arb_pick #(
    .NUM_M (NUM_M),
    .MW    (MW)
  ) u_pick (
    .req   (hbusreq_i),
    .owner (owner_p0),
    .excl  (pick_excl),
    .win   (pick_win),
    .vld   (pick_vld)
  );

  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (owner_p0 == MW'(i)) begin
        owner_req = hbusreq_i[i];
      end
    end
  end

  always_comb begin
    state_nx = state_p0;
    owner_nx = owner_p0;
    case (state_p0)
      ARB_PARK: begin
        if (pick_vld) begin
          state_nx = ARB_OWN;
          owner_nx = pick_win;
        end else begin
          owner_nx = DEF_IDX;
        end
      end
      ARB_OWN: begin
        // A SEQ beat belongs to a running burst: never re-arbitrate on it.
        if (htrans_i != HTRANS_SEQ) begin
          if (!owner_req) begin
            if (pick_vld) begin
              owner_nx = pick_win;
            end else begin
              state_nx = ARB_PARK;
              owner_nx = DEF_IDX;
            end
          end else if ((tenure_p0 == TEN_MAX) && pick_vld) begin
            owner_nx = pick_win;
          end
        end
      end
      default: begin
        state_nx = ARB_PARK;
        owner_nx = DEF_IDX;
      end
    endcase
  end

  always_comb begin
    grant_nx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      grant_nx[i] = (owner_nx == MW'(i));
    end
  end

  // Leaving PARK clears the counter even when the default master itself
  // becomes owner (grant vector unchanged, tenure starts fresh).
  always_comb begin
    tenure_nx = tenure_p0;
    if ((owner_nx != owner_p0) || (state_p0 == ARB_PARK)) begin
      tenure_nx = '0;
    end else if (htrans_active(htrans_i)) begin
      tenure_nx = tenure_sat_inc(tenure_p0);
    end
  end

  // Stage p0: address-phase ownership; stage p1: data-phase owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0  <= ARB_PARK;
      owner_p0  <= DEF_IDX;
      owner_p1  <= DEF_IDX;
      grant_p0  <= DEF_GRANT;
      tenure_p0 <= '0;
    end else if (hready_i) begin
      state_p0  <= state_nx;
      owner_p0  <= owner_nx;
      owner_p1  <= owner_p0;
      grant_p0  <= grant_nx;
      tenure_p0 <= tenure_nx;
    end
  end

  assign hgrant_o    = grant_p0;
  assign hmaster_o   = owner_p0;
  assign hmaster_d_o = owner_p1;
  assign parked_o    = (state_p0 == ARB_PARK);

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_bus_arbiter
//   Directed scoreboard bench. A 2-master arbiter (MAX_TENURE=8) covers
//   grant latency, stalls, SEQ bursts, tenure limit, saturation and async
//   reset; a 3-master arbiter (MAX_TENURE=2) covers the picker rotation,
//   with expected order chosen by AHB_ARB_RR_EN.
// ---------------------------------------------------------------------------
module tb_ahb_bus_arbiter;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

`ifdef AHB_ARB_RR_EN
  localparam logic [1:0] X1 = 2'd2;
  localparam logic [1:0] X2 = 2'd0;
  localparam logic [1:0] X3 = 2'd1;
`else
  localparam logic [1:0] X1 = 2'd0;
  localparam logic [1:0] X2 = 2'd1;
  localparam logic [1:0] X3 = 2'd0;
`endif

  typedef struct {
    string      name;
    logic [2:0] grant;
    logic [2:0] master;
    logic [2:0] mdata;
    logic       parked;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] hbusreq;
  logic [1:0] htrans;
  logic       hready;
  logic [1:0] hgrant;
  logic [2:0] hmaster;
  logic [2:0] hmaster_d;
  logic       parked;

  logic [2:0] req3;
  logic [1:0] trans3;
  logic       rdy3;
  logic [2:0] grant3;
  logic [1:0] master3;
  logic [1:0] master3_d;
  logic       parked3;

  exp_t q[$];
  exp_t q3[$];
  int   checks = 0;
  int   errors = 0;
  logic [1:0] prev3;

  ahb_bus_arbiter #(
    .NUM_M(2), .MW(3), .DEF_MASTER(0), .MAX_TENURE(8)
  ) u_dut (
    .clk(clk), .rst(rst), .hbusreq_i(hbusreq), .htrans_i(htrans),
    .hready_i(hready), .hgrant_o(hgrant), .hmaster_o(hmaster),
    .hmaster_d_o(hmaster_d), .parked_o(parked)
  );

  ahb_bus_arbiter #(
    .NUM_M(3), .MW(2), .DEF_MASTER(0), .MAX_TENURE(2)
  ) u_dut3 (
    .clk(clk), .rst(rst), .hbusreq_i(req3), .htrans_i(trans3),
    .hready_i(rdy3), .hgrant_o(grant3), .hmaster_o(master3),
    .hmaster_d_o(master3_d), .parked_o(parked3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Monitor for the 2-master arbiter: checks after each clock edge and on
  // asynchronous reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (hgrant !== e.grant[1:0] || hmaster !== e.master ||
            hmaster_d !== e.mdata || parked !== e.parked) begin
          errors++;
          $display("FAIL %s: got grant=%b master=%0d mdata=%0d parked=%b, want grant=%b master=%0d mdata=%0d parked=%b",
                   e.name, hgrant, hmaster, hmaster_d, parked,
                   e.grant[1:0], e.master, e.mdata, e.parked);
        end
      end
    end
  end

  // Monitor for the 3-master arbiter.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q3.size() > 0) begin
        e = q3.pop_front();
        checks++;
        if (grant3 !== e.grant || master3 !== e.master[1:0] ||
            master3_d !== e.mdata[1:0] || parked3 !== e.parked) begin
          errors++;
          $display("FAIL %s: got grant=%b master=%0d mdata=%0d parked=%b, want grant=%b master=%0d mdata=%0d parked=%b",
                   e.name, grant3, master3, master3_d, parked3,
                   e.grant, e.master[1:0], e.mdata[1:0], e.parked);
        end
      end
    end
  end

  // Drive one cycle on the 2-master arbiter and queue the state expected
  // after the coming rising edge.
  task automatic step(input string nm, input logic [1:0] req, input logic [1:0] tr,
                      input logic rdy, input logic [1:0] g, input logic [2:0] m,
                      input logic [2:0] d, input logic p);
    hbusreq = req;
    htrans  = tr;
    hready  = rdy;
    q.push_back('{name: nm, grant: {1'b0, g}, master: m, mdata: d, parked: p});
    @(negedge clk);
  endtask

  // Same for the 3-master arbiter; only the expected owner is given, the
  // data-phase owner expected is the previous expected owner.
  task automatic step3(input string nm, input logic [2:0] req, input logic [1:0] m);
    req3   = req;
    trans3 = T_NONSEQ;
    rdy3   = 1'b1;
    q3.push_back('{name: nm, grant: 3'b001 << m, master: {1'b0, m},
                   mdata: {1'b0, prev3}, parked: 1'b0});
    prev3 = m;
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    hbusreq = 2'b00;
    htrans  = T_IDLE;
    hready  = 1'b1;
    req3    = 3'b000;
    trans3  = T_IDLE;
    rdy3    = 1'b1;
    prev3   = 2'd0;

    #3;
    q.push_back('{name: "reset", grant: 3'b001, master: 3'd0, mdata: 3'd0, parked: 1'b1});
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Grant latency and data-phase owner
    step("t1_grant_m1", 2'b10, T_IDLE,   1'b1, 2'b10, 3'd1, 3'd0, 1'b0);
    step("t1_dphase",   2'b10, T_NONSEQ, 1'b1, 2'b10, 3'd1, 3'd1, 1'b0);

    // Wait states freeze everything, release parks
    for (int i = 0; i < 3; i++)
      step("t2_stall",  2'b00, T_IDLE, 1'b0, 2'b10, 3'd1, 3'd1, 1'b0);
    step("t2_release",  2'b00, T_IDLE, 1'b1, 2'b01, 3'd0, 3'd1, 1'b1);
    step("t2_park",     2'b00, T_IDLE, 1'b1, 2'b01, 3'd0, 3'd0, 1'b1);

    // Default master requests from PARK, then SEQ burst is not split
    step("t3_def_req",   2'b01, T_NONSEQ, 1'b1, 2'b01, 3'd0, 3'd0, 1'b0);
    step("t3_hold",      2'b01, T_NONSEQ, 1'b1, 2'b01, 3'd0, 3'd0, 1'b0);
    step("t3_seq",       2'b10, T_SEQ,    1'b1, 2'b01, 3'd0, 3'd0, 1'b0);
    step("t3_seq_stall", 2'b10, T_SEQ,    1'b0, 2'b01, 3'd0, 3'd0, 1'b0);
    step("t3_switch",    2'b10, T_IDLE,   1'b1, 2'b10, 3'd1, 3'd0, 1'b0);
    step("t3_dphase",    2'b10, T_IDLE,   1'b1, 2'b10, 3'd1, 3'd1, 1'b0);
    step("t3_park",      2'b00, T_IDLE,   1'b1, 2'b01, 3'd0, 3'd1, 1'b1);
    step("t3_park2",     2'b00, T_IDLE,   1'b1, 2'b01, 3'd0, 3'd0, 1'b1);

    // Tenure limit alternation
    step("t4_m0", 2'b01, T_NONSEQ, 1'b1, 2'b01, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      step("t4_m0_tenure", 2'b11, T_NONSEQ, 1'b1, 2'b01, 3'd0, 3'd0, 1'b0);
    step("t4_yield_m1", 2'b11, T_NONSEQ, 1'b1, 2'b10, 3'd1, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++)
      step("t4_m1_tenure", 2'b11, T_NONSEQ, 1'b1, 2'b10, 3'd1, 3'd1, 1'b0);
    step("t4_yield_m0",  2'b11, T_NONSEQ, 1'b1, 2'b01, 3'd0, 3'd1, 1'b0);
    step("t4_m0_again",  2'b11, T_NONSEQ, 1'b1, 2'b01, 3'd0, 3'd0, 1'b0);

    // Counter saturates at the limit: contender gets the bus at once
    for (int i = 0; i < 10; i++)
      step("t5_sat", 2'b01, T_NONSEQ, 1'b1, 2'b01, 3'd0, 3'd0, 1'b0);
    step("t5_yield", 2'b11, T_NONSEQ, 1'b1, 2'b10, 3'd1, 3'd0, 1'b0);

    // IDLE cycles are not transfers and do not age the tenure
    for (int i = 0; i < 12; i++)
      step("t6_idle", 2'b11, T_IDLE, 1'b1, 2'b10, 3'd1, 3'd1, 1'b0);
    step("t6_nonseq", 2'b11, T_NONSEQ, 1'b1, 2'b10, 3'd1, 3'd1, 1'b0);

    // Asynchronous reset mid-transfer while master 1 owns
    q.push_back('{name: "t7_async_rst", grant: 3'b001, master: 3'd0, mdata: 3'd0, parked: 1'b1});
    #2;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step("t7_after", 2'b00, T_IDLE, 1'b1, 2'b01, 3'd0, 3'd0, 1'b1);
    step("t7_req",   2'b10, T_IDLE, 1'b1, 2'b10, 3'd1, 3'd0, 1'b0);
    step("t7_drop",  2'b00, T_IDLE, 1'b1, 2'b01, 3'd0, 3'd1, 1'b1);

    // 3-master rotation at the tenure limit (MAX_TENURE=2)
    step3("r3_m1",    3'b010, 2'd1);
    step3("r3_hold1", 3'b111, 2'd1);
    step3("r3_hold1", 3'b111, 2'd1);
    step3("r3_x1",    3'b111, X1);
    step3("r3_holdx1", 3'b111, X1);
    step3("r3_holdx1", 3'b111, X1);
    step3("r3_x2",    3'b111, X2);
    step3("r3_holdx2", 3'b111, X2);
    step3("r3_holdx2", 3'b111, X2);
    step3("r3_x3",    3'b111, X3);

    repeat (2) @(negedge clk);
    if (q.size() != 0 || q3.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d/%0d expectations left unchecked, want 0/0", q.size(), q3.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
